// File: rtl/transposer_ctrl.sv
// Sequencing controller for a bit-plane transposer: loads a parallel block,
// then walks the bit select LSB- or MSB-first, one slice per downstream handshake.
module transposer_ctrl #(
    parameter int SEL_BITS = 4,
    parameter int WL       = 16,
    parameter int WORDS    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORDS*WL-1:0]   in_data,
    input  logic [SEL_BITS:0]     in_prec,
    input  logic                  in_msb_first,
    output logic                  tp_enable,
    output logic [WORDS*WL-1:0]   tp_data,
    output logic [SEL_BITS:0]     tp_sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_first,
    output logic                  out_last,
    output logic [15:0]           blk_cnt,
    output logic                  dbg_state
);

    localparam int SW = SEL_BITS + 1;
    localparam logic [SEL_BITS:0] WL_SEL = SW'(WL);
    localparam logic [SEL_BITS:0] ONE    = SW'(1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t            state;
    logic [SEL_BITS:0] prec_q;
    logic              msb_q;
    logic [15:0]       blk_cnt_q;

    logic [SEL_BITS:0] prec_eff;
    logic [SEL_BITS:0] load_sel;
    logic [SEL_BITS:0] step_sel;
    logic [SEL_BITS:0] end_sel;
    logic              hs;

    // Handshakes: a transfer happens on a side exactly when valid && ready are
    // both high at a rising edge; valid never waits on ready. in_ready is built
    // only from registered state and out_ready, so tp_enable cannot loop back.
    assign hs        = out_valid && out_ready;
    assign in_ready  = (state == IDLE) || (out_last && out_ready);
    assign tp_enable = in_valid && in_ready;
    assign tp_data   = in_data;
    assign blk_cnt   = blk_cnt_q;
    assign dbg_state = state;

    // A zero or oversized precision means a full-width word.
    assign prec_eff = ((in_prec == '0) || (in_prec > WL_SEL)) ? WL_SEL : in_prec;
    assign load_sel = in_msb_first ? (prec_eff - ONE) : '0;
    assign step_sel = msb_q ? (tp_sel - ONE) : (tp_sel + ONE);
    assign end_sel  = msb_q ? '0 : (prec_q - ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prec_q    <= '0;
            msb_q     <= 1'b0;
            tp_sel    <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            blk_cnt_q <= '0;
        end else begin
            if (hs && out_last) begin
                blk_cnt_q <= blk_cnt_q + 16'd1;
            end
            // In STREAM a load can only coincide with the last-slice handshake,
            // which gives the zero-bubble hand-over between blocks.
            if (tp_enable) begin
                state     <= STREAM;
                prec_q    <= prec_eff;
                msb_q     <= in_msb_first;
                tp_sel    <= load_sel;
                out_valid <= 1'b1;
                out_first <= 1'b1;
                out_last  <= (prec_eff == ONE);
            end else if (state == STREAM && hs) begin
                if (out_last) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_first <= 1'b0;
                    out_last  <= 1'b0;
                end else begin
                    tp_sel    <= step_sel;
                    out_first <= 1'b0;
                    out_last  <= (step_sel == end_sel);
                end
            end
        end
    end

endmodule

// File: tb/tb_transposer_ctrl.sv
// Randomized bench for transposer_ctrl: a queue of expected slices per block is
// compared every cycle against the controller outputs.
module tb_transposer_ctrl;

    localparam int SEL_BITS = 4;
    localparam int WL       = 16;
    localparam int WORDS    = 16;
    localparam int DW       = WORDS * WL;
    localparam int SB       = SEL_BITS + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [SB-1:0] in_prec = '0;
    logic          in_msb_first = 1'b0;
    logic          tp_enable;
    logic [DW-1:0] tp_data;
    logic [SB-1:0] tp_sel;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_first;
    logic          out_last;
    logic [15:0]   blk_cnt;
    logic          dbg_state;

    transposer_ctrl #(.SEL_BITS(SEL_BITS), .WL(WL), .WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_prec(in_prec), .in_msb_first(in_msb_first),
        .tp_enable(tp_enable), .tp_data(tp_data), .tp_sel(tp_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_first(out_first), .out_last(out_last),
        .blk_cnt(blk_cnt), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Each entry is {sel, first, last} for one slice still owed downstream.
    logic [SB+1:0] exp_q[$];
    logic [15:0]   exp_blk = '0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Queue the slices a block of the given precision and order must produce.
    task automatic model_load(input logic [SB-1:0] prec, input logic msb);
        int p;
        int s;
        logic [SB-1:0] sv;
        p = (prec == 0 || prec > WL) ? WL : int'(prec);
        for (int i = 0; i < p; i++) begin
            s  = msb ? (p - 1 - i) : i;
            sv = s[SB-1:0];
            exp_q.push_back({sv, (i == 0), (i == p - 1)});
        end
    endtask

    // One clock: drive inputs, check outputs, then advance the model past the edge.
    task automatic cycle(input logic iv, input logic [SB-1:0] prec, input logic msb, input logic ordy);
        logic [SB+1:0] head;
        logic active;
        logic exp_rdy;
        logic exp_load;
        @(negedge clk);
        in_valid     = iv;
        in_prec      = prec;
        in_msb_first = msb;
        out_ready    = ordy;
        for (int w = 0; w < DW / 32; w++) in_data[w*32 +: 32] = $urandom;
        #1;
        active   = (exp_q.size() != 0);
        head     = active ? exp_q[0] : '0;
        exp_rdy  = !active || (head[0] && ordy);
        exp_load = iv && exp_rdy;
        check("out_valid", out_valid, active);
        check("state", dbg_state, active);
        if (active) begin
            check("tp_sel", tp_sel, head[SB+1:2]);
            check("out_first", out_first, head[1]);
            check("out_last", out_last, head[0]);
        end
        check("in_ready", in_ready, exp_rdy);
        check("tp_enable", tp_enable, exp_load);
        check("tp_data", tp_data, in_data);
        check("blk_cnt", blk_cnt, exp_blk);
        if (active && ordy) begin
            void'(exp_q.pop_front());
            if (head[0]) exp_blk++;
        end
        if (exp_load) model_load(prec, msb);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_tp_sel", tp_sel, '0);
        check("rst_blk_cnt", blk_cnt, '0);
        check("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single LSB-first block of precision 4.
        cycle(1'b1, 5'd4, 1'b0, 1'b1);
        idle(6);

        // MSB-first precision 8 with three stalled cycles at tp_sel 5.
        cycle(1'b1, 5'd8, 1'b1, 1'b1);
        idle(2);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0);
        idle(8);

        // Back-to-back blocks of precision 3 then 2 with in_valid held high.
        cycle(1'b1, 5'd3, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 5'd2, 1'b0, 1'b1);
        idle(4);

        // Precision clamping and the single-slice block.
        cycle(1'b1, 5'd0, 1'b0, 1'b1);
        idle(17);
        cycle(1'b1, 5'd20, 1'b1, 1'b1);
        idle(17);
        cycle(1'b1, 5'd1, 1'b1, 1'b1);
        idle(2);

        // Asynchronous reset while the second slice of a 16-bit block is showing.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        exp_blk = '0;
        cycle(1'b1, 5'd16, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_tp_sel", tp_sel, '0);
        check("arst_out_first", out_first, 1'b0);
        check("arst_out_last", out_last, 1'b0);
        check("arst_blk_cnt", blk_cnt, '0);
        check("arst_in_ready", in_ready, 1'b1);
        exp_q.delete();
        exp_blk = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 5'd4, 1'b0, 1'b1);
        idle(5);

        // Counter wrap from 65535.
        force dut.blk_cnt_q = 16'hFFFF;
        #1;
        release dut.blk_cnt_q;
        exp_blk = 16'hFFFF;
        cycle(1'b1, 5'd2, 1'b0, 1'b1);
        idle(3);

        // Random traffic: mostly short blocks, random backpressure and order.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 5)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0));
        end
        idle(20);
        check("drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/transposer_ctrl.md
TRANSPOSER_CTRL -- requirements
Module: transposer_ctrl

Interface
REQ-001 Parameter SEL_BITS, default 4: bit-select index width is SEL_BITS+1.
REQ-002 Parameter WL, default 16: word length and maximum precision in bits.
REQ-003 Parameter WORDS, default 16: words per block and stream lanes.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  upstream block present.
REQ-007 in_ready  output  1  controller accepts the block this cycle.
REQ-008 in_data  input  WORDS*WL  parallel block, word i at bits [i*WL+WL-1 : i*WL].
REQ-009 in_prec  input  SEL_BITS+1  block precision in bits, sampled with the block.
REQ-010 in_msb_first  input  1  stream order for the block, sampled with the block.
REQ-011 tp_enable  output  1  transposer load strobe.
REQ-012 tp_data  output  WORDS*WL  equals in_data (pass-through wire).
REQ-013 tp_sel  output  SEL_BITS+1  transposer bit select.
REQ-014 out_valid  output  1  transposer stream holds a valid bit-slice.
REQ-015 out_ready  input  1  downstream consumes the slice.
REQ-016 out_first, out_last  output  1 each  first or last slice of the current block.
REQ-017 blk_cnt  output  16  count of completed blocks.

Function
REQ-018 The state machine SHALL have exactly two states, IDLE and STREAM.
REQ-019 in_ready SHALL be 1 in IDLE, and 1 in STREAM only when out_last && out_ready.
REQ-020 tp_enable SHALL equal in_valid && in_ready, with no combinational path from tp_enable back to in_ready.
REQ-021 On a load, the controller SHALL latch prec_q = in_prec, clamped so that 0 or any value greater than WL becomes WL.
REQ-022 On a load, the controller SHALL latch msb_q = in_msb_first and enter STREAM the next cycle.
REQ-023 On a load, the registered tp_sel SHALL become prec_q-1 if msb_q, else 0.
REQ-024 In STREAM, out_valid SHALL be 1 and the transposer stream SHALL hold bit tp_sel of every word.
REQ-025 A handshake (out_valid && out_ready) on a non-last slice SHALL step tp_sel by +1 (LSB-first) or -1 (MSB-first).
REQ-026 When out_ready is 0, tp_sel, out_first and out_last SHALL hold.
REQ-027 out_first SHALL be 1 only on the first slice of a block.
REQ-028 out_last SHALL be 1 when tp_sel equals prec_q-1 (LSB-first) or 0 (MSB-first).
REQ-029 For prec_q = 1, out_first and out_last SHALL both be 1 on the single slice.
REQ-030 A handshake on the last slice SHALL increment blk_cnt, wrapping from 65535 to 0.
REQ-031 If in_valid is 1 during that last-slice handshake, the next block SHALL load in the same cycle and STREAM SHALL continue with zero bubble cycles.
REQ-032 If in_valid is 0 during that last-slice handshake, the state SHALL return to IDLE.
REQ-033 Each block SHALL produce exactly prec_q slices, each handshaken exactly once.
REQ-034 tp_sel SHALL never leave the range 0..WL-1.

Reset
REQ-035 While rst_n = 0, state SHALL be IDLE, and tp_sel, out_valid, out_first, out_last, blk_cnt, prec_q and msb_q SHALL be 0.
REQ-036 The reset values SHALL apply asynchronously, with no clock edge required.
REQ-037 Reset asserted mid-block SHALL discard the block without incrementing blk_cnt.
REQ-038 After rst_n deasserts, the block SHALL reach IDLE with in_ready = 1 on the first edge.

Verification
REQ-039 Single block, LSB-first: data 64'h0003000A000E000F, in_prec = 4, out_ready held 1 -> tp_sel 0,1,2,3 on consecutive cycles; out_first on tp_sel 0; out_last on tp_sel 3; blk_cnt = 1; IDLE afterwards.
REQ-040 MSB-first with backpressure: in_prec = 8, out_ready low for 3 cycles at tp_sel 5 -> tp_sel sequence 7,6,5,5,5,5,4..0; exactly 8 handshakes.
REQ-041 Back-to-back blocks: in_valid held high with precisions 3 then 2 -> 5 consecutive out_valid cycles with no gap; tp_enable pulses on the cycle of the last slice of block 1; blk_cnt = 2.
REQ-042 Clamp cases: in_prec = 0 and in_prec = 20 -> 16 slices each; in_prec = 1 -> one slice with out_first = out_last = 1.
REQ-043 Reset at the 2nd slice of a 16-bit block -> outputs zero immediately without a clock edge; blk_cnt unchanged; next load streams from tp_sel 0.
REQ-044 Wrap: preload blk_cnt = 65535 by forcing it, then complete 1 block -> blk_cnt = 0.
